ddr3_wb_traffic_gen: RTL and testbench
======================================

Name: ddr3_wb_traffic_gen

Overview:
- Wishbone pipelined-mode initiator (bus master) that drives the DDR3 controller's Wishbone slave port.
- On a start pulse it writes a deterministic pattern to NUM_REQS consecutive burst addresses, then reads them back and checks every returned beat.
- It sits beside the DDR3 top level and serves as the built-in memory self-test and traffic source for bring-up and hardware regression.

Parameters:
- WB_ADDR_BITS, 24, width of burst-granular Wishbone address.
- WB_DATA_BITS, 512, Wishbone data width; must be a multiple of 32.
- WB_SEL_BITS, WB_DATA_BITS/8, byte-select width.
- NUM_REQS, 256, transfers per phase (1..65535).
- TIMEOUT, 1024, maximum cycles to wait for an ack while requests are outstanding.

Ports:
- i_controller_clk  in  1  sole clock, controller-clock domain.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle start pulse; honoured only in IDLE or DONE.
- i_base_addr  in  WB_ADDR_BITS  first burst address.
- i_seed  in  32  pattern seed.
- o_busy  out  1  high from start until DONE.
- o_done  out  1  high in DONE.
- o_pass  out  1  valid with o_done: err_count==0 and no timeout.
- o_timeout  out  1  sticky ack-timeout flag.
- o_err_count  out  16  mismatching read beats; saturates at 16'hFFFF.
- o_first_err_addr  out  WB_ADDR_BITS  address of the first failing read.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  WB_ADDR_BITS  request address.
- o_wb_data  out  WB_DATA_BITS  write data.
- o_wb_sel  out  WB_SEL_BITS  byte enables; always all-ones.
- o_aux  out  1  tag equal to o_wb_we.
- i_wb_stall, i_wb_ack  in  1 each  slave responses.
- i_wb_data  in  WB_DATA_BITS  read data.
- i_aux  in  1  returned tag.

Behaviour:

Reset:
- All outputs 0.
- State IDLE; all counters 0.
- Reset is asynchronous and may assert mid-transfer; cyc/stb drop immediately, with no bus cleanup.

State machine: IDLE -> WRITE -> WRITE_WAIT -> READ -> READ_WAIT -> DONE.
- A start in IDLE or DONE clears err_count, timeout, first_err_addr, issue_cnt and ack_cnt, then enters WRITE.
- A start received in any other state is ignored.

Issue:
- In WRITE and READ, o_wb_stb=1 while issue_cnt<NUM_REQS.
- A request is accepted when stb && !i_wb_stall; acceptance increments issue_cnt.
- The request fields are registered and held stable while stalled: o_wb_addr = i_base_addr + issue_cnt (mod 2^WB_ADDR_BITS), o_wb_we = 1 in WRITE, 0 in READ, o_aux = o_wb_we.
- When the last request is accepted, stb drops the next cycle and the machine moves to WRITE_WAIT or READ_WAIT.

Pattern:
- For beat n, 32-bit word k = i_seed + n*(WB_DATA_BITS/32) + k, mod 2^32.
- Write data uses n = issue_cnt. The read-check expectation uses n = ack_cnt; acks return in issue order.

Acks:
- Each i_wb_ack increments ack_cnt. Acks are counted in every phase, including the same cycle as an issue.
- WRITE_WAIT -> READ when ack_cnt reaches NUM_REQS. ack_cnt and issue_cnt reset on that transition.
- A read ack is an error if i_wb_data differs from the expected pattern or i_aux != 0.
- A write ack is an error if i_aux != 1.
- On the first error, capture o_first_err_addr = i_base_addr + ack_cnt.
- An ack with zero outstanding requests (ack_cnt == issue_cnt) is counted as an error and does not advance ack_cnt.

Completion and timeout:
- READ_WAIT -> DONE when ack_cnt reaches NUM_REQS.
- While outstanding > 0, count cycles without an ack. At TIMEOUT, set o_timeout, drop cyc/stb, and go to DONE.
- o_wb_cyc is high continuously from WRITE entry through READ_WAIT exit; it drops in the cycle DONE is entered.
- In DONE, o_pass = (err_count == 0) && !o_timeout.

Latency:
- With the slave never stalling and 1-cycle acks, the whole test completes in about 2*NUM_REQS + 4 cycles.

Test Plan:
- Zero-latency responder model (ack 1 cycle after accept, stall=0), NUM_REQS=4, seed=0, base=0x10 -> 4 writes at 0x10..0x13, then 4 reads; done=1, pass=1, err_count=0.
- Responder that stalls 3 of every 4 cycles -> addr/data/we held stable during stall; every address issued exactly once; pass=1.
- Memory model flips bit 0 of the beat at 0x12 on readback -> err_count=1, first_err_addr=0x12, pass=0.
- Responder that never acks after the 2nd write, TIMEOUT=16 -> timeout=1 after 16 idle cycles, cyc=0, done=1, pass=0.
- base=0xFFFFFE, NUM_REQS=4 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; pass=1.
- Assert i_rst during READ with requests outstanding -> all outputs 0 immediately; a subsequent start runs a full clean test that passes.

Source files
------------

// File: rtl/ddr3_wb_traffic_gen.sv
// Wishbone pipelined-mode traffic generator and memory self-test for the DDR3 controller.
// On i_start it writes a seed-derived pattern to NUM_REQS consecutive burst addresses,
// then reads them back and checks every returned beat.
//
// Ports:
//   i_controller_clk, i_rst      clock, asynchronous active-high reset
//   i_start                      start pulse (honoured in IDLE or DONE)
//   i_base_addr, i_seed          first burst address, pattern seed (latched at start)
//   o_busy, o_done, o_pass       run status; o_pass valid with o_done
//   o_timeout                    sticky ack-timeout flag
//   o_err_count                  mismatching beats, saturating
//   o_first_err_addr             address of the first failing ack
//   o_wb_*, o_aux                Wishbone master request side
//   i_wb_stall, i_wb_ack,
//   i_wb_data, i_aux             Wishbone slave response side
module ddr3_wb_traffic_gen #(
  parameter int unsigned WB_ADDR_BITS = 24,
  parameter int unsigned WB_DATA_BITS = 512,
  parameter int unsigned WB_SEL_BITS  = WB_DATA_BITS / 8,
  parameter int unsigned NUM_REQS     = 256,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                    i_controller_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [WB_ADDR_BITS-1:0] i_base_addr,
  input  logic [31:0]             i_seed,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_timeout,
  output logic [15:0]             o_err_count,
  output logic [WB_ADDR_BITS-1:0] o_first_err_addr,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [WB_ADDR_BITS-1:0] o_wb_addr,
  output logic [WB_DATA_BITS-1:0] o_wb_data,
  output logic [WB_SEL_BITS-1:0]  o_wb_sel,
  output logic                    o_aux,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic [WB_DATA_BITS-1:0] i_wb_data,
  input  logic                    i_aux
);

  localparam int unsigned Words = WB_DATA_BITS / 32;
  localparam int unsigned CntW  = $clog2(NUM_REQS + 1);
  localparam int unsigned TmrW  = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] NumReqs       = CntW'(NUM_REQS);
  localparam logic [TmrW-1:0] TimeoutCycles = TmrW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StWrite, StWriteWait, StRead, StReadWait, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         issue_q, issue_d;
  logic [CntW-1:0]         ack_q, ack_d;
  logic [TmrW-1:0]         timer_q, timer_d;
  logic [15:0]             err_q, err_d;
  logic                    timeout_q, timeout_d;
  logic [WB_ADDR_BITS-1:0] first_err_q, first_err_d;
  logic [WB_ADDR_BITS-1:0] base_q, base_d;
  logic [31:0]             seed_q, seed_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [WB_ADDR_BITS-1:0] addr_q, addr_d;
  logic [WB_DATA_BITS-1:0] data_q, data_d;

  logic active, reading, ack_err;

  // Beat n, word k = seed + n*Words + k.
  function automatic logic [WB_DATA_BITS-1:0] pattern(input logic [31:0]     seed,
                                                      input logic [CntW-1:0] n);
    logic [WB_DATA_BITS-1:0] p;
    logic [31:0]             first;
    p     = '0;
    first = seed + 32'(n) * 32'(Words);
    for (int k = 0; k < int'(Words); k++) begin
      p[k*32 +: 32] = first + 32'(k);
    end
    return p;
  endfunction

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    ack_d       = ack_q;
    timer_d     = timer_q;
    err_d       = err_q;
    timeout_d   = timeout_q;
    first_err_d = first_err_q;
    base_d      = base_q;
    seed_d      = seed_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    active      = 1'b0;
    reading     = 1'b0;
    ack_err     = 1'b0;

    unique case (state_q)
      StWrite, StWriteWait: active = 1'b1;
      StRead, StReadWait: begin
        active  = 1'b1;
        reading = 1'b1;
      end
      default: ;
    endcase

    if (!active) begin
      if (i_start) begin
        base_d      = i_base_addr;
        seed_d      = i_seed;
        issue_d     = '0;
        ack_d       = '0;
        timer_d     = '0;
        err_d       = '0;
        timeout_d   = 1'b0;
        first_err_d = '0;
        cyc_d       = 1'b1;
        stb_d       = 1'b1;
        we_d        = 1'b1;
        addr_d      = i_base_addr;
        data_d      = pattern(i_seed, '0);
        state_d     = StWrite;
      end
    end else begin
      // Response side. An ack with nothing outstanding is flagged but not counted.
      if (i_wb_ack) begin
        if (ack_q == issue_q) begin
          ack_err = 1'b1;
        end else begin
          ack_d = ack_q + 1'b1;
          if (reading) begin
            ack_err = (i_wb_data != pattern(seed_q, ack_q)) || i_aux;
          end else begin
            ack_err = !i_aux;
          end
        end
      end
      if (ack_err) begin
        if (err_q == 16'd0) first_err_d = base_q + WB_ADDR_BITS'(ack_q);
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end

      // Request side: fields only advance on acceptance, so they hold while stalled.
      if (stb_q && !i_wb_stall) begin
        issue_d = issue_q + 1'b1;
        if (issue_d == NumReqs) begin
          stb_d   = 1'b0;
          state_d = reading ? StReadWait : StWriteWait;
        end else begin
          addr_d = base_q + WB_ADDR_BITS'(issue_d);
          data_d = reading ? '0 : pattern(seed_q, issue_d);
        end
      end

      if ((issue_q != ack_q) && !i_wb_ack) timer_d = timer_q + 1'b1;
      else timer_d = '0;

      if ((state_q == StWriteWait) && (ack_d == NumReqs)) begin
        issue_d = '0;
        ack_d   = '0;
        timer_d = '0;
        stb_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = base_q;
        data_d  = '0;
        state_d = StRead;
      end else if ((state_q == StReadWait) && (ack_d == NumReqs)) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        state_d = StDone;
      end

      if (timer_d == TimeoutCycles) begin
        timeout_d = 1'b1;
        cyc_d     = 1'b0;
        stb_d     = 1'b0;
        we_d      = 1'b0;
        state_d   = StDone;
      end
    end
  end

  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      issue_q     <= '0;
      ack_q       <= '0;
      timer_q     <= '0;
      err_q       <= '0;
      timeout_q   <= 1'b0;
      first_err_q <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      ack_q       <= ack_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      first_err_q <= first_err_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign o_busy           = (state_q != StIdle) && (state_q != StDone);
  assign o_done           = (state_q == StDone);
  assign o_pass           = o_done && (err_q == 16'd0) && !timeout_q;
  assign o_timeout        = timeout_q;
  assign o_err_count      = err_q;
  assign o_first_err_addr = first_err_q;
  assign o_wb_cyc         = cyc_q;
  assign o_wb_stb         = stb_q;
  assign o_wb_we          = we_q;
  assign o_wb_addr        = addr_q;
  assign o_wb_data        = data_q;
  // All byte lanes enabled on every request; zero outside a bus cycle so reset is all-zero.
  assign o_wb_sel         = {WB_SEL_BITS{cyc_q}};
  assign o_aux            = we_q;

endmodule

// File: tb/tb_ddr3_wb_traffic_gen.sv
module tb_ddr3_wb_traffic_gen;

  localparam int AW    = 24;
  localparam int DW    = 128;
  localparam int SW    = DW / 8;
  localparam int NR    = 4;
  localparam int TO    = 16;
  localparam int WORDS = DW / 32;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [31:0]   i_seed = '0;
  logic          o_busy, o_done, o_pass, o_timeout;
  logic [15:0]   o_err_count;
  logic [AW-1:0] o_first_err_addr;
  logic          o_wb_cyc, o_wb_stb, o_wb_we, o_aux;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [SW-1:0] o_wb_sel;
  logic          i_wb_stall, i_wb_ack, i_aux;
  logic [DW-1:0] i_wb_data;

  always #5 clk = ~clk;

  ddr3_wb_traffic_gen #(
    .WB_ADDR_BITS(AW), .WB_DATA_BITS(DW), .WB_SEL_BITS(SW), .NUM_REQS(NR), .TIMEOUT(TO)
  ) dut (
    .i_controller_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_seed(i_seed), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_timeout(o_timeout), .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .o_aux(o_aux), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data), .i_aux(i_aux)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input logic [31:0] seed, input int n);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < WORDS; k++) b[k*32 +: 32] = seed + 32'(n * WORDS + k);
    return b;
  endfunction

  // Responder: 1-cycle ack after acceptance, optional 3-of-4 stall, bit flip, ack cutoff.
  bit            stall_mode = 1'b0;
  bit            flip_en = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  int            ack_limit = 1 << 30;
  int            acks_sent;
  logic [1:0]    stall_cnt;
  logic [DW-1:0] mem [256];

  always @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      i_wb_ack   <= 1'b0;
      i_wb_data  <= '0;
      i_aux      <= 1'b0;
      i_wb_stall <= 1'b0;
      stall_cnt  <= '0;
      acks_sent  <= 0;
    end else begin
      stall_cnt  <= stall_cnt + 2'd1;
      i_wb_stall <= stall_mode && (stall_cnt != 2'd2);
      i_wb_ack   <= 1'b0;
      i_aux      <= 1'b0;
      i_wb_data  <= '0;
      if (i_start) acks_sent <= 0;
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
        if (o_wb_we) mem[o_wb_addr[7:0]] <= o_wb_data;
        if (acks_sent < ack_limit) begin
          i_wb_ack  <= 1'b1;
          i_aux     <= o_aux;
          acks_sent <= acks_sent + 1;
          if (!o_wb_we) begin
            i_wb_data <= mem[o_wb_addr[7:0]] ^
                         ((flip_en && (o_wb_addr == flip_addr)) ? {{(DW-1){1'b0}}, 1'b1} : '0);
          end
        end
      end
    end
  end

  // Scoreboard of expected requests, popped as the DUT's requests are accepted.
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } req_t;
  req_t sb[$];

  logic          held_v = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  logic          held_we;

  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (!i_rst && o_wb_cyc && o_wb_stb) begin
        if (held_v) begin
          check("hold_addr", DW'(o_wb_addr), DW'(held_addr));
          check("hold_we", DW'(o_wb_we), DW'(held_we));
          check("hold_data", o_wb_data, held_data);
        end
        if (i_wb_stall) begin
          held_v    = 1'b1;
          held_addr = o_wb_addr;
          held_data = o_wb_data;
          held_we   = o_wb_we;
        end else begin
          held_v = 1'b0;
          check("req_expected", DW'(sb.size() != 0), DW'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("req_addr", DW'(o_wb_addr), DW'(e.addr));
            check("req_we", DW'(o_wb_we), DW'(e.we));
            check("req_aux", DW'(o_aux), DW'(e.we));
            check("req_sel", DW'(o_wb_sel), DW'({SW{1'b1}}));
            if (e.we) check("req_wdata", o_wb_data, e.data);
          end
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic start_test(input logic [AW-1:0] base, input logic [31:0] seed,
                            input bit with_reads);
    req_t e;
    logic [AW-1:0] a;
    for (int n = 0; n < NR; n++) begin
      a = base + AW'(n);
      e.addr = a; e.we = 1'b1; e.data = beat(seed, n);
      sb.push_back(e);
    end
    if (with_reads) begin
      for (int n = 0; n < NR; n++) begin
        a = base + AW'(n);
        e.addr = a; e.we = 1'b0; e.data = '0;
        sb.push_back(e);
      end
    end
    i_base_addr = base;
    i_seed      = seed;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!o_done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done"}, DW'(o_done), DW'(1));
  endtask

  task automatic check_result(input string tag, input bit pass, input logic [15:0] errs,
                              input logic [AW-1:0] first, input bit tmo);
    check({tag, "_pass"}, DW'(o_pass), DW'(pass));
    check({tag, "_err_count"}, DW'(o_err_count), DW'(errs));
    check({tag, "_first_err"}, DW'(o_first_err_addr), DW'(first));
    check({tag, "_timeout"}, DW'(o_timeout), DW'(tmo));
    check({tag, "_cyc_low"}, DW'(o_wb_cyc), DW'(0));
    check({tag, "_busy_low"}, DW'(o_busy), DW'(0));
    check({tag, "_sb_drained"}, DW'(sb.size()), DW'(0));
  endtask

  initial begin
    int  cyc;
    bit  seen;
    #2 i_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", DW'({o_busy, o_done, o_pass, o_timeout, o_wb_cyc, o_wb_stb, o_wb_we,
                           o_aux}), DW'(0));
    check("rst_counts", DW'({o_err_count, o_first_err_addr, o_wb_addr}), DW'(0));
    check("rst_data_sel", {o_wb_data[DW-1:SW], o_wb_data[SW-1:0] | o_wb_sel}, '0);
    i_rst = 1'b0;
    @(negedge clk);

    // Basic write/read-back, no stall.
    start_test(24'h000010, 32'h0, 1'b1);
    check("t1_busy", DW'(o_busy), DW'(1));
    wait_done("t1", 200, cyc);
    check("t1_latency", DW'(cyc <= 2 * NR + 4), DW'(1));
    check_result("t1", 1'b1, 16'd0, '0, 1'b0);

    // Heavy stalling; a start pulse mid-run must be ignored.
    stall_mode = 1'b1;
    start_test(24'h000020, 32'hCAFE_0000, 1'b1);
    repeat (5) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("t2", 400, cyc);
    check_result("t2", 1'b1, 16'd0, '0, 1'b0);
    stall_mode = 1'b0;

    // Corrupt readback of the beat at 0x12.
    flip_en   = 1'b1;
    flip_addr = 24'h000012;
    start_test(24'h000010, 32'h1234_5678, 1'b1);
    wait_done("t3", 200, cyc);
    check_result("t3", 1'b0, 16'd1, 24'h000012, 1'b0);
    flip_en = 1'b0;

    // Acks stop after the second write.
    ack_limit = 2;
    start_test(24'h000030, 32'h0000_0100, 1'b0);
    repeat (11) @(negedge clk);
    check("t4_no_early_timeout", DW'({o_timeout, o_done}), DW'(0));
    wait_done("t4", 200, cyc);
    cyc += 12;
    check("t4_timeout_delay", DW'(cyc >= 18 && cyc <= 20), DW'(1));
    check_result("t4", 1'b0, 16'd0, '0, 1'b1);
    ack_limit = 1 << 30;

    // Address wraps at the top of the burst space.
    start_test(24'hFFFFFE, 32'hFFFF_FFF0, 1'b1);
    wait_done("t5", 200, cyc);
    check_result("t5", 1'b1, 16'd0, '0, 1'b0);

    // Reset during READ with a request outstanding, then a clean rerun.
    start_test(24'h000040, 32'h0000_ABCD, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = o_wb_cyc && o_wb_stb && !o_wb_we && !i_wb_stall;
    end
    check("t6_read_phase_seen", DW'(seen), DW'(1));
    @(posedge clk);
    #2 i_rst = 1'b1;
    #1;
    check("t6_rst_ctrl", DW'({o_busy, o_done, o_pass, o_timeout, o_wb_cyc, o_wb_stb, o_wb_we,
                              o_aux}), DW'(0));
    check("t6_rst_counts", DW'({o_err_count, o_first_err_addr, o_wb_addr}), DW'(0));
    check("t6_rst_data", o_wb_data, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    start_test(24'h000050, 32'h5A5A_0000, 1'b1);
    wait_done("t6", 200, cyc);
    check_result("t6", 1'b1, 16'd0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
